// File: rtl/nn_pkg.sv
// Shared constants, element type and helpers for the pooling / dense datapath.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int POOL_W = IMG_W / 2;
  localparam int POOL_H = IMG_H / 2;

  typedef logic signed [DATA_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_t;

  // Signed maximum; on a tie either operand gives the same value.
  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 signed max-pool. Consumes one raster-order frame,
// one pixel per accepted beat, and builds the registered pooled array that
// feeds the dense layer. Even rows fold pixel pairs into a line buffer, odd
// rows combine with it and retire one pooled element per odd column.
module max_pool_stream
  import nn_pkg::pool_state_t;
  import nn_pkg::ST_IDLE;
  import nn_pkg::ST_RUN;
  import nn_pkg::ST_DONE;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IMG_W  = nn_pkg::IMG_W,
  parameter int IMG_H  = nn_pkg::IMG_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pix_valid,
  input  logic signed [DATA_W-1:0] pix_in,
  output logic                     pix_ready,
  output logic                     busy,
  output logic signed [DATA_W-1:0] pooled_img [0:(IMG_H/2)*(IMG_W/2)-1],
  output logic                     pool_done
);

  localparam int POOL_W = IMG_W / 2;
  localparam int POOL_H = IMG_H / 2;
  localparam int NPOOL  = POOL_W * POOL_H;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int LW     = $clog2(POOL_W);
  localparam int PW     = $clog2(NPOOL);

  function automatic logic signed [DATA_W-1:0] pmax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

  pool_state_t              r_state;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic                     r_busy;
  logic                     r_done;
  logic signed [DATA_W-1:0] r_hold;
  logic signed [DATA_W-1:0] r_line [0:POOL_W-1];
  logic signed [DATA_W-1:0] r_pool [0:NPOOL-1];

  logic          w_acc;
  logic          w_last;
  logic [LW-1:0] w_lidx;
  logic [PW-1:0] w_pidx;

  // Beat acceptance, end-of-frame detection and buffer addressing.
  always_comb begin
    w_acc  = (r_state == ST_RUN) && pix_valid && !start;
    w_last = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));
    w_lidx = LW'(int'(r_col) / 2);
    w_pidx = PW'((int'(r_row) / 2) * POOL_W + int'(r_col) / 2);
  end

  // Frame FSM with raster counters and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_state <= ST_RUN;
      r_col   <= '0;
      r_row   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (w_acc) begin
      if (w_last) begin
        r_state <= ST_DONE;
        r_col   <= '0;
        r_row   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Pooling datapath: hold register, line buffer and pooled output array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      for (int i = 0; i < POOL_W; i++) r_line[i] <= '0;
      for (int i = 0; i < NPOOL; i++)  r_pool[i] <= '0;
    end else if (start) begin
      r_hold <= '0;
    end else if (w_acc) begin
      case ({r_row[0], r_col[0]})
        2'b00:   r_hold         <= pix_in;
        2'b01:   r_line[w_lidx] <= pmax(r_hold, pix_in);
        2'b10:   r_hold         <= pmax(r_line[w_lidx], pix_in);
        default: r_pool[w_pidx] <= pmax(r_hold, pix_in);
      endcase
    end
  end

  assign pix_ready  = r_busy;
  assign busy       = r_busy;
  assign pool_done  = r_done;
  assign pooled_img = r_pool;

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: ramp, negative values, bubbles,
// restart, asynchronous reset mid-frame and an upsampled digit pattern.
module tb_max_pool_stream;

  localparam int NP = 196;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               pix_valid;
  logic signed [15:0] pix_in;
  logic               pix_ready;
  logic               busy;
  logic signed [15:0] pooled_img [0:NP-1];
  logic               pool_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  max_pool_stream dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .pooled_img (pooled_img),
    .pool_done  (pool_done)
  );

  // 14x14 source pattern for the upsampling scenario.
  function automatic logic signed [15:0] digit(input int pr, input int pc);
    return 16'(((pr * 37 + pc * 11) % 256) - 128);
  endfunction

  // kind 0 ramp, 1 negatives, 2 upsampled digit, 3 constant filler
  function automatic logic signed [15:0] pix(input int kind, input int r, input int c);
    case (kind)
      0: return 16'(r * 28 + c);
      1: begin
        if (r == 0 && c == 1)        return -16'sd1;
        else if (r == 27 && c == 27) return -16'sd32768;
        else                         return -16'sd5;
      end
      2: return digit(r / 2, c / 2);
      default: return 16'sd30000;
    endcase
  endfunction

  function automatic logic signed [15:0] exp_pool(input int kind, input int i);
    int pr, pc;
    pr = i / 14;
    pc = i % 14;
    case (kind)
      0: return 16'((2 * pr + 1) * 28 + 2 * pc + 1);
      1: return (i == 0) ? -16'sd1 : -16'sd5;
      default: return digit(pr, pc);
    endcase
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beats(input int kind, input bit bubbles, input int first, input int count);
    for (int b = first; b < first + count; b++) begin
      if (bubbles && ($urandom_range(0, 1) == 1)) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      pix_in    = pix(kind, b / 28, b % 28);
      @(posedge clk); #1;
      pix_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({busy, pix_ready, pool_done} !== 3'b000) $display("FAIL reset_ctl got=%b exp=000", {busy, pix_ready, pool_done});
    else n_pass++;
    bad = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== 16'sd0) bad++;
    n_total++;
    if (bad != 0) $display("FAIL reset_pool nonzero=%0d exp=0", bad);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    int bad, bi;
    pulse_start();
    n_total++;
    if (busy !== 1'b1 || pix_ready !== 1'b1) $display("FAIL ramp_busy got=%b%b exp=11", busy, pix_ready);
    else n_pass++;
    beats(0, 1'b0, 0, 29);
    n_total++;
    if (pooled_img[0] !== 16'sd0) $display("FAIL ramp_p0_early got=%0d exp=0", pooled_img[0]);
    else n_pass++;
    beats(0, 1'b0, 29, 1);
    n_total++;
    if (pooled_img[0] !== 16'sd29) $display("FAIL ramp_p0_latency got=%0d exp=29", pooled_img[0]);
    else n_pass++;
    beats(0, 1'b0, 30, 753);
    n_total++;
    if (pool_done !== 1'b0 || busy !== 1'b1) $display("FAIL ramp_pre_done got=%b%b exp=01", pool_done, busy);
    else n_pass++;
    beats(0, 1'b0, 783, 1);
    n_total++;
    if ({pool_done, busy, pix_ready} !== 3'b100) $display("FAIL ramp_done got=%b exp=100", {pool_done, busy, pix_ready});
    else n_pass++;
    n_total++;
    if (pooled_img[13] !== 16'sd55) $display("FAIL ramp_p13 got=%0d exp=55", pooled_img[13]);
    else n_pass++;
    n_total++;
    if (pooled_img[195] !== 16'sd783) $display("FAIL ramp_p195 got=%0d exp=783", pooled_img[195]);
    else n_pass++;
    bad = 0; bi = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== exp_pool(0, i)) begin if (bad == 0) bi = i; bad++; end
    n_total++;
    if (bad != 0) $display("FAIL ramp_frame idx=%0d got=%0d exp=%0d bad=%0d", bi, pooled_img[bi], exp_pool(0, bi), bad);
    else n_pass++;
  endtask

  task automatic test_negatives();
    int bad, bi;
    pulse_start();
    beats(1, 1'b0, 0, 784);
    n_total++;
    if (pool_done !== 1'b1) $display("FAIL neg_done got=%b exp=1", pool_done);
    else n_pass++;
    n_total++;
    if (pooled_img[0] !== -16'sd1) $display("FAIL neg_p0 got=%0d exp=-1", pooled_img[0]);
    else n_pass++;
    n_total++;
    if (pooled_img[195] !== -16'sd5) $display("FAIL neg_p195 got=%0d exp=-5", pooled_img[195]);
    else n_pass++;
    bad = 0; bi = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== exp_pool(1, i)) begin if (bad == 0) bi = i; bad++; end
    n_total++;
    if (bad != 0) $display("FAIL neg_frame idx=%0d got=%0d exp=%0d bad=%0d", bi, pooled_img[bi], exp_pool(1, bi), bad);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    int bad, bi;
    pulse_start();
    beats(0, 1'b1, 0, 783);
    n_total++;
    if (pool_done !== 1'b0) $display("FAIL bub_pre_done got=%b exp=0", pool_done);
    else n_pass++;
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (pool_done !== 1'b0 || busy !== 1'b1) $display("FAIL bub_stall got=%b%b exp=01", pool_done, busy);
    else n_pass++;
    beats(0, 1'b1, 783, 1);
    n_total++;
    if (pool_done !== 1'b1) $display("FAIL bub_done got=%b exp=1", pool_done);
    else n_pass++;
    bad = 0; bi = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== exp_pool(0, i)) begin if (bad == 0) bi = i; bad++; end
    n_total++;
    if (bad != 0) $display("FAIL bub_frame idx=%0d got=%0d exp=%0d bad=%0d", bi, pooled_img[bi], exp_pool(0, bi), bad);
    else n_pass++;
  endtask

  task automatic test_restart();
    int bad, bi;
    n_total++;
    if (pix_ready !== 1'b0) $display("FAIL rst_ready_idle got=%b exp=0", pix_ready);
    else n_pass++;
    beats(3, 1'b0, 0, 10);
    n_total++;
    if (pooled_img[0] !== 16'sd29) $display("FAIL rst_ignored got=%0d exp=29", pooled_img[0]);
    else n_pass++;
    pulse_start();
    n_total++;
    if (pool_done !== 1'b0 || busy !== 1'b1) $display("FAIL rst_start1 got=%b%b exp=01", pool_done, busy);
    else n_pass++;
    beats(3, 1'b0, 0, 300);
    n_total++;
    if (pooled_img[0] !== 16'sd30000) $display("FAIL rst_partial got=%0d exp=30000", pooled_img[0]);
    else n_pass++;
    pulse_start();
    beats(0, 1'b0, 0, 783);
    n_total++;
    if (pool_done !== 1'b0) $display("FAIL rst_pre_done got=%b exp=0", pool_done);
    else n_pass++;
    beats(0, 1'b0, 783, 1);
    n_total++;
    if (pool_done !== 1'b1) $display("FAIL rst_done got=%b exp=1", pool_done);
    else n_pass++;
    bad = 0; bi = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== exp_pool(0, i)) begin if (bad == 0) bi = i; bad++; end
    n_total++;
    if (bad != 0) $display("FAIL rst_frame idx=%0d got=%0d exp=%0d bad=%0d", bi, pooled_img[bi], exp_pool(0, bi), bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad, bi;
    pulse_start();
    beats(0, 1'b0, 0, 500);
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if ({busy, pix_ready, pool_done} !== 3'b000) $display("FAIL mid_ctl got=%b exp=000", {busy, pix_ready, pool_done});
    else n_pass++;
    bad = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== 16'sd0) bad++;
    n_total++;
    if (bad != 0) $display("FAIL mid_pool nonzero=%0d exp=0", bad);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    beats(0, 1'b0, 0, 784);
    n_total++;
    if (pool_done !== 1'b1) $display("FAIL mid_done got=%b exp=1", pool_done);
    else n_pass++;
    bad = 0; bi = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== exp_pool(0, i)) begin if (bad == 0) bi = i; bad++; end
    n_total++;
    if (bad != 0) $display("FAIL mid_frame idx=%0d got=%0d exp=%0d bad=%0d", bi, pooled_img[bi], exp_pool(0, bi), bad);
    else n_pass++;
  endtask

  task automatic test_upsample();
    int bad, bi;
    pulse_start();
    beats(2, 1'b1, 0, 784);
    n_total++;
    if (pool_done !== 1'b1) $display("FAIL up_done got=%b exp=1", pool_done);
    else n_pass++;
    bad = 0; bi = 0;
    for (int i = 0; i < NP; i++) if (pooled_img[i] !== exp_pool(2, i)) begin if (bad == 0) bi = i; bad++; end
    n_total++;
    if (bad != 0) $display("FAIL up_frame idx=%0d got=%0d exp=%0d bad=%0d", bi, pooled_img[bi], exp_pool(2, bi), bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negatives();
    test_bubbles();
    test_restart();
    test_reset_mid();
    test_upsample();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
